// File: rtl/shift_pkg.sv
// shift_pkg: shared op and FSM state encodings for the shift unit
package shift_pkg;
  typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROR = 2'b11} op_t;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: one bounded shift/rotate of up to STEP bits through log2 mux stages
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 8,
  parameter int DW    = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [DW-1:0]    d,
  input  op_t              op,
  input  logic             fill,
  output logic [WIDTH-1:0] res
);
  logic [DW:0][WIDTH-1:0] st;
  assign st[0] = acc;
  for (genvar k = 0; k < DW; k++) begin : g_stage
    logic [WIDTH-1:0]   hi;
    logic [2*WIDTH-1:0] wide;
    assign hi       = op == OP_ROR ? st[k] : {WIDTH{op == OP_SRA && fill}};
    assign wide     = {hi, st[k]} >> (1 << k);
    assign st[k+1]  = !d[k] ? st[k] : op == OP_SLL ? st[k] << (1 << k) : wide[WIDTH-1:0];
  end
  assign res = st[DW];
endmodule

// File: rtl/shift_unit.sv
// shift_unit: multi-cycle shifter applying at most STEP bits of shift per busy cycle
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 8,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  localparam int DW = $clog2(STEP) + 1;
  state_t           state, state_nx;
  logic [WIDTH-1:0] acc, shifted;
  logic [SHW-1:0]   rem;
  op_t              op;
  logic             fill;
  logic [DW-1:0]    d;
  logic             accept;
  assign accept    = in_valid && in_ready;
  assign d         = (STEP >= WIDTH || int'(rem) <= STEP) ? DW'(rem) : DW'(STEP);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign out_data  = out_valid ? acc : '0;
  shift_step #(.WIDTH(WIDTH), .STEP(STEP), .DW(DW)) u_step (
    .acc (acc),
    .d   (d),
    .op  (op),
    .fill(fill),
    .res (shifted)
  );
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // next state: zero-distance requests skip straight to DONE
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (accept ? (in_amt != '0 ? BUSY : DONE) : IDLE)
             : state == BUSY ? (rem == SHW'(d) ? DONE : BUSY)
             : state == DONE ? (out_ready ? IDLE : DONE)
             : IDLE;
  end
  // operand registers; sign fill is captured once so SRA stays arithmetic across steps
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      rem  <= '0;
      op   <= OP_SLL;
      fill <= 1'b0;
    end else if (accept) begin
      acc  <= in_data;
      rem  <= in_amt;
      op   <= op_t'(in_op);
      fill <= in_data[WIDTH-1];
    end else if (state == BUSY) begin
      acc  <= shifted;
      rem  <= rem - SHW'(d);
    end
  end
endmodule
